uart_mem_responder: RTL and testbench

- Synthesizable memory server at the host end of the picorv_uart memory-over-UART link; the FPGA-side counterpart of the bench-only uart_sender.
- Consumes request frames from a byte-stream UART receiver, services them from a local word RAM, and returns response bytes to a UART transmitter.
- Sits between existing uart_rx/uart_tx byte cores; lets the picorv_uart core boot and run against on-board memory instead of a host program.

---
 rtl/uart_mem_pkg.sv | 28 ++
 rtl/mem_bram.sv | 31 +++
 rtl/uart_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_uart_mem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_pkg.sv
// Shared definitions for the memory-over-UART link.
// Used by the responder, its RAM wrapper and anything that speaks the protocol
// (initiator core, benches).
//   state_e         : responder frame-handling states
//   CmdRead         : command byte for a word read
//   CmdWriteMask    : command bits carrying the write byte strobes
//   DefaultAckByte  : byte returned once a write has been committed
package uart_mem_pkg;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        WDATA,
        WR,
        RD,
        RSP
    } state_e;

    localparam logic [7:0] CmdRead        = 8'h00;
    localparam logic [7:0] CmdWriteMask   = 8'h0F;
    localparam logic [7:0] DefaultAckByte = 8'hA5;

    // Commands 0x00..0x0F are legal; anything with a high nibble set is not.
    function automatic logic is_valid_cmd(input logic [7:0] b);
        return (b & ~CmdWriteMask) == 8'h00;
    endfunction

endpackage

// File: rtl/mem_bram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Reads are registered (one-cycle latency) and return the old word when a
// write hits the same address in the same cycle.
//   clk   : clock
//   addr  : word index
//   we    : byte write enables, we[i] covers wdata[8*i +: 8]
//   wdata : write word
//   rdata : read word, valid the cycle after addr is presented
module mem_bram #(
    parameter int    DepthWords = 1024,
    parameter string InitFile   = ""
) (
    input  logic                          clk,
    input  logic [$clog2(DepthWords)-1:0] addr,
    input  logic [3:0]                    we,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata
);

    logic [31:0] mem_array [DepthWords];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_array[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem_array[addr];
    end

endmodule

// File: rtl/uart_mem_responder.sv
// Memory server for the memory-over-UART link. Parses request frames from a
// byte receiver, services them from a local word RAM and streams response
// bytes to a byte transmitter.
//   clk_i      : clock
//   reset_i    : synchronous reset, active low
//   rx_data_i  : received byte        rx_valid_i : byte valid
//   rx_ready_o : byte accepted this cycle
//   tx_data_o  : byte to transmit     tx_valid_o : byte valid
//   tx_ready_i : transmitter accepts the byte
//   busy_o     : a frame or response is in progress
//   err_o      : one-cycle pulse on bad command, range error or timeout
module uart_mem_responder
    import uart_mem_pkg::*;
#(
    parameter int         DepthWords    = 1024,
    parameter string      InitFile      = "",
    parameter int         TimeoutCycles = 20000,
    parameter logic [7:0] AckByte       = DefaultAckByte
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    localparam int IdxW = $clog2(DepthWords);
    localparam int TmoW = $clog2(TimeoutCycles + 1);

    state_e            state_reg, state_next;
    logic [3:0]        cmd_reg, cmd_next;       // wstrb; zero means read
    logic [2:0]        cnt_reg, cnt_next;       // frame byte index / bytes left to send
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       shift_reg, shift_next;   // response bytes, LSB goes out first
    logic [TmoW-1:0]   tmo_reg, tmo_next;
    logic              err_reg, err_next;

    logic              rx_fire, tx_fire, in_range;
    logic [IdxW-1:0]   ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;

    assign rx_ready_o = reset_i && (state_reg == CMD || state_reg == ADDR || state_reg == WDATA);
    assign tx_valid_o = (state_reg == RSP);
    assign tx_data_o  = shift_reg[7:0];
    assign busy_o     = (state_reg != CMD);
    assign err_o      = err_reg;

    assign rx_fire  = rx_valid_i && rx_ready_o;
    assign tx_fire  = tx_valid_o && tx_ready_i;
    assign in_range = ({2'b00, addr_reg[31:2]} < DepthWords);

    // The RAM is addressed from the next-state address so the read launches on
    // the same edge that accepts the final address byte; RD then only has to
    // capture the data, giving a two-cycle turnaround.
    assign ram_addr = addr_next[IdxW+1:2];
    assign ram_we   = (state_reg == WR && in_range) ? cmd_reg : 4'h0;

    mem_bram #(
        .DepthWords (DepthWords),
        .InitFile   (InitFile)
    ) u_mem (
        .clk   (clk_i),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        shift_next = shift_reg;
        tmo_next   = tmo_reg;
        err_next   = 1'b0;

        unique case (state_reg)
            CMD: begin
                if (rx_fire) begin
                    if (is_valid_cmd(rx_data_i)) begin
                        cmd_next   = rx_data_i[3:0];
                        cnt_next   = 3'd0;
                        tmo_next   = '0;
                        state_next = ADDR;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ADDR, WDATA: begin
                if (rx_fire) begin
                    if (state_reg == ADDR) begin
                        addr_next[8*cnt_reg[1:0] +: 8] = rx_data_i;
                    end else begin
                        wdata_next[8*cnt_reg[1:0] +: 8] = rx_data_i;
                    end
                    tmo_next = '0;
                    cnt_next = cnt_reg + 3'd1;
                    if (cnt_reg == 3'd3) begin
                        cnt_next = 3'd0;
                        if (state_reg == WDATA) begin
                            state_next = WR;
                        end else if (cmd_reg != 4'h0) begin
                            state_next = WDATA;
                        end else begin
                            state_next = RD;
                        end
                    end
                end else if (tmo_reg == TmoW'(TimeoutCycles - 1)) begin
                    err_next   = 1'b1;
                    cnt_next   = 3'd0;
                    tmo_next   = '0;
                    state_next = CMD;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            WR: begin
                err_next   = !in_range;
                shift_next = {24'h0, AckByte};
                cnt_next   = 3'd1;
                state_next = RSP;
            end
            RD: begin
                err_next   = !in_range;
                shift_next = in_range ? ram_rdata : 32'h0;
                cnt_next   = 3'd4;
                state_next = RSP;
            end
            RSP: begin
                if (tx_fire) begin
                    shift_next = shift_reg >> 8;
                    cnt_next   = cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        cnt_next   = 3'd0;
                        state_next = CMD;
                    end
                end
            end
            default: state_next = CMD;
        endcase
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_reg <= CMD;
            cmd_reg   <= 4'h0;
            cnt_reg   <= 3'd0;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            shift_reg <= 32'h0;
            tmo_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            shift_reg <= shift_next;
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_uart_mem_responder.sv
// Directed bench for uart_mem_responder: frames in, response bytes checked
// against hand-computed words, plus error, timeout, stall and reset cases.
module tb_uart_mem_responder;
    import uart_mem_pkg::*;

    localparam int Tmo = 100;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    uart_mem_responder #(
        .DepthWords    (1024),
        .InitFile      (""),
        .TimeoutCycles (Tmo),
        .AckByte       (DefaultAckByte)
    ) dut (
        .clk_i      (clk),
        .reset_i    (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // err is a registered one-cycle pulse, so one sample per cycle counts it once.
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no end of test, expected $finish before 2ms");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            check_eq("rx_ready_timeout", {31'h0, rx_ready}, 32'h1);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(addr[i*8 +: 8]);
    endtask

    // lat counts falling edges from the return of the last send to the first valid byte.
    task automatic get_resp(input int nbytes, output logic [31:0] word, output int lat);
        int got = 0;
        int waited = 0;
        word = 32'h0;
        lat  = -1;
        while (got < nbytes && waited < 1000) begin
            if (tx_valid && tx_ready) begin
                if (got == 0) lat = waited;
                word[got*8 +: 8] = tx_data;
                got++;
            end
            @(negedge clk);
            waited++;
        end
        if (got < nbytes) check_eq("resp_timeout", got, nbytes);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] w;
        int lat;
        send_hdr(CmdRead, addr);
        get_resp(4, w, lat);
        $display("read  addr=%08h data=%08h", addr, w);
        check_eq({tag, "_data"}, w, exp);
        check_eq({tag, "_lat"}, lat, 1);
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input string tag);
        logic [31:0] w;
        int lat;
        send_hdr(cmd, addr);
        for (int i = 0; i < 4; i++) send_byte(data[i*8 +: 8]);
        get_resp(1, w, lat);
        $display("write cmd=%02h addr=%08h data=%08h ack=%02h", cmd, addr, data, w[7:0]);
        check_eq({tag, "_ack"}, w, {24'h0, DefaultAckByte});
        check_eq({tag, "_lat"}, lat, 1);
    endtask

    task automatic wait_tx_valid(input string tag);
        int n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'h0, tx_valid}, 32'h1);
    endtask

    initial begin
        int e0;
        int bad;
        logic [7:0] held;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check_eq("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check_eq("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        $display("reset released");

        // Full write then read of word 5.
        e0 = err_cnt;
        do_write(8'h0F, 32'h14, 32'hCAFEBABE, "wr_w5");
        do_read(32'h14, 32'hCAFEBABE, "rd_w5");
        check_eq("rd_w5_no_err", err_cnt - e0, 0);

        // Read-after-write, then byte-strobed updates of word 8.
        do_write(8'h0F, 32'h20, 32'h12345678, "wr_w8");
        do_read(32'h20, 32'h12345678, "rd_w8");
        do_write(8'h03, 32'h20, 32'hDEADBEEF, "wr_w8_lo");
        do_read(32'h20, 32'h1234BEEF, "rd_w8_lo");
        do_write(8'h0C, 32'h20, 32'hDEADBEEF, "wr_w8_hi");
        do_read(32'h20, 32'hDEADBEEF, "rd_w8_hi");

        // Last in-range word and ignored low address bits.
        do_write(8'h0F, 32'hFFC, 32'h5A5AA5A5, "wr_last");
        do_read(32'hFFC, 32'h5A5AA5A5, "rd_last");
        do_write(8'h0F, 32'h0, 32'h0BADF00D, "wr_w0");
        do_read(32'h3, 32'h0BADF00D, "rd_w0_lowbits");

        // Out of range: 0x1000 would alias word 0 if the range check were missing.
        e0 = err_cnt;
        do_read(32'h1000, 32'h0, "rd_oor");
        check_eq("rd_oor_err", err_cnt - e0, 1);
        e0 = err_cnt;
        do_write(8'h0F, 32'h1000, 32'h11223344, "wr_oor");
        check_eq("wr_oor_err", err_cnt - e0, 1);
        do_read(32'h0, 32'h0BADF00D, "rd_w0_kept");

        // Illegal command byte.
        e0 = err_cnt;
        send_byte(8'h42);
        repeat (3) @(negedge clk);
        $display("bad cmd 42 sent");
        check_eq("badcmd_err", err_cnt - e0, 1);
        check_eq("badcmd_tx_valid", {31'h0, tx_valid}, 32'h0);
        check_eq("badcmd_busy", {31'h0, busy}, 32'h0);

        // Stalled partial frame times out after exactly Tmo idle cycles.
        e0 = err_cnt;
        send_byte(8'h00);
        send_byte(8'h14);
        send_byte(8'h00);
        repeat (Tmo - 1) @(negedge clk);
        check_eq("tmo_early_err", err_cnt - e0, 0);
        check_eq("tmo_early_busy", {31'h0, busy}, 32'h1);
        repeat (5) @(negedge clk);
        $display("partial frame abandoned");
        check_eq("tmo_err", err_cnt - e0, 1);
        check_eq("tmo_busy", {31'h0, busy}, 32'h0);
        do_read(32'h14, 32'hCAFEBABE, "rd_after_tmo");

        // Transmitter back-pressure mid-response.
        tx_ready = 1'b0;
        send_hdr(CmdRead, 32'h14);
        wait_tx_valid("stall_valid");
        held = tx_data;
        check_eq("stall_first", {24'h0, held}, 32'h000000BE);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_data !== held || tx_valid !== 1'b1) bad++;
        end
        check_eq("stall_stable", bad, 0);
        begin
            logic [31:0] w;
            int lat;
            tx_ready = 1'b1;
            get_resp(4, w, lat);
            $display("read  addr=%08h data=%08h (after stall)", 32'h14, w);
            check_eq("stall_data", w, 32'hCAFEBABE);
        end

        // Reset in the middle of a response.
        tx_ready = 1'b0;
        send_hdr(CmdRead, 32'h20);
        wait_tx_valid("rsp_rst_valid");
        rst_n = 1'b0;
        @(negedge clk);
        $display("reset during response");
        check_eq("rsp_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check_eq("rsp_rst_tx_data", {24'h0, tx_data}, 32'h0);
        check_eq("rsp_rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rsp_rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        do_read(32'h20, 32'hDEADBEEF, "rd_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
